// File: rtl/sram_pkg.sv
// sram_pkg: shared types and elaboration-time helpers for the single-port
// SRAM wrapper.
//   state_e       : wrapper control state (INIT sweep, READY for requests)
//   clog2         : address width for a given entry count
//   params_legal  : parameter legality (mask granularity, read latency, depth)
package sram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

  function automatic bit params_legal(input int data_width, input int mask_gran,
                                      input int read_latency, input int depth);
    return (mask_gran > 0) && ((data_width % mask_gran) == 0) &&
           ((read_latency == 1) || (read_latency == 2)) && (depth >= 2);
  endfunction

endpackage

// File: rtl/sram_array_sp.sv
// sram_array_sp: behavioural single-port storage with a lane-masked write and
// a registered read address (read data valid one cycle after the read).
// Stands in for the foundry macro at synthesis.
// Ports:
//   clock  in   clock
//   en     in   port access this cycle
//   wen    in   1 = write, 0 = read
//   addr   in   entry index (always < DEPTH when en is high)
//   wmask  in   lane enables, bit i covers wdata[i*MASK_GRAN +: MASK_GRAN]
//   wdata  in   write data
//   rdata  out  data at the address captured by the last read
module sram_array_sp
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = clog2(DEPTH),
  parameter int MASK_GRAN  = 8,
  parameter int MASK_WIDTH = DATA_WIDTH / MASK_GRAN
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [MASK_WIDTH-1:0] wmask,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] raddr_p0;

  always_ff @(posedge clock) begin
    if (en && wen) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (wmask[i]) mem[addr][i*MASK_GRAN +: MASK_GRAN] <= wdata[i*MASK_GRAN +: MASK_GRAN];
      end
    end
    if (en && !wen) raddr_p0 <= addr;
  end

  assign rdata = mem[raddr_p0];

endmodule

// File: rtl/sram_sp_init_wrapper.sv
// sram_sp_init_wrapper: single-port SRAM with a hardware init sweep after
// reset, READ_LATENCY of 1 or 2 cycles, and an optional read-data hold.
// Ports:
//   clock, reset    clock and synchronous active-high reset
//   io_req_valid    request present (ignored until the sweep is done)
//   io_req_ready    high in READY
//   io_req_wen      1 = write, 0 = read
//   io_req_addr     entry index; indices >= DEPTH drop writes, read INIT_VALUE
//   io_req_wmask    lane write enables
//   io_req_wdata    write data
//   io_resp_valid   one pulse per read, READ_LATENCY cycles after the fire
//   io_resp_rdata   read data (held or zeroed between responses)
//   io_init_done    sweep complete, stays high until the next reset
module sram_sp_init_wrapper
  import sram_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 64,
  parameter int                    DEPTH        = 256,
  parameter int                    ADDR_WIDTH   = clog2(DEPTH),
  parameter int                    MASK_GRAN    = 8,
  parameter int                    MASK_WIDTH   = DATA_WIDTH / MASK_GRAN,
  parameter int                    READ_LATENCY = 1,
  parameter bit                    HOLD_RDATA   = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_req_valid,
  output logic                  io_req_ready,
  input  logic                  io_req_wen,
  input  logic [ADDR_WIDTH-1:0] io_req_addr,
  input  logic [MASK_WIDTH-1:0] io_req_wmask,
  input  logic [DATA_WIDTH-1:0] io_req_wdata,
  output logic                  io_resp_valid,
  output logic [DATA_WIDTH-1:0] io_resp_rdata,
  output logic                  io_init_done
);

  if (!params_legal(DATA_WIDTH, MASK_GRAN, READ_LATENCY, DEPTH)) begin : g_bad_params
    $error("sram_sp_init_wrapper: illegal DATA_WIDTH/MASK_GRAN/READ_LATENCY/DEPTH");
  end

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_ptr_q, init_ptr_d;
  logic                  arr_en, arr_wen;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [MASK_WIDTH-1:0] arr_wmask;
  logic [DATA_WIDTH-1:0] arr_wdata, arr_rdata;
  logic                  req_oob, rd_fire, rd_oob;
  logic                  vld_p1, oob_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  resp_vld;
  logic [DATA_WIDTH-1:0] resp_data;

  // Out-of-range indices only exist when DEPTH is not a power of two.
  if (DEPTH == (1 << ADDR_WIDTH)) begin : g_pow2
    assign req_oob = 1'b0;
  end else begin : g_npow2
    assign req_oob = (32'(io_req_addr) >= 32'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  // Sweep owns the array port in INIT; requests own it in READY.
  // Out-of-range accesses never reach the array.
  always_comb begin
    state_d      = state_q;
    init_ptr_d   = init_ptr_q;
    arr_en       = 1'b0;
    arr_wen      = 1'b0;
    arr_addr     = '0;
    arr_wmask    = '0;
    arr_wdata    = '0;
    rd_fire      = 1'b0;
    rd_oob       = 1'b0;
    io_req_ready = 1'b0;
    io_init_done = 1'b0;
    case (state_q)
      INIT: begin
        arr_en     = 1'b1;
        arr_wen    = 1'b1;
        arr_addr   = init_ptr_q;
        arr_wmask  = '1;
        arr_wdata  = INIT_VALUE;
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == LAST_IDX) state_d = READY;
      end
      READY: begin
        io_req_ready = 1'b1;
        io_init_done = 1'b1;
        if (io_req_valid) begin
          if (io_req_wen) begin
            arr_en    = !req_oob;
            arr_wen   = 1'b1;
            arr_addr  = io_req_addr;
            arr_wmask = io_req_wmask;
            arr_wdata = io_req_wdata;
          end else begin
            rd_fire  = 1'b1;
            rd_oob   = req_oob;
            arr_en   = !req_oob;
            arr_addr = io_req_addr;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  sram_array_sp #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .MASK_GRAN (MASK_GRAN),
    .MASK_WIDTH(MASK_WIDTH)
  ) u_array (
    .clock(clock),
    .en   (arr_en),
    .wen  (arr_wen),
    .addr (arr_addr),
    .wmask(arr_wmask),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

  // ---- stage p1: array read data available ----
  always_ff @(posedge clock) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= rd_fire;
  end

  always_ff @(posedge clock) begin
    oob_p1 <= rd_oob;
  end

  assign data_p1 = oob_p1 ? INIT_VALUE : arr_rdata;

  // ---- stage p2: optional output register ----
  if (READ_LATENCY == 2) begin : g_lat2
    logic                  vld_p2;
    logic [DATA_WIDTH-1:0] data_p2;

    always_ff @(posedge clock) begin
      if (reset) vld_p2 <= 1'b0;
      else       vld_p2 <= vld_p1;
    end

    always_ff @(posedge clock) begin
      if (vld_p1) data_p2 <= data_p1;
    end

    assign resp_vld  = vld_p2;
    assign resp_data = data_p2;
  end else begin : g_lat1
    assign resp_vld  = vld_p1;
    assign resp_data = data_p1;
  end

  assign io_resp_valid = resp_vld;

  // Hold register is cleared by reset so rdata is never X after reset.
  if (HOLD_RDATA) begin : g_hold
    logic [DATA_WIDTH-1:0] hold_q;

    always_ff @(posedge clock) begin
      if (reset)         hold_q <= '0;
      else if (resp_vld) hold_q <= resp_data;
    end

    assign io_resp_rdata = resp_vld ? resp_data : hold_q;
  end else begin : g_zero
    assign io_resp_rdata = resp_vld ? resp_data : '0;
  end

endmodule
